csa_mul_pipe: RTL and testbench



---
 rtl/csa_mul_pipe.sv | 166 ++++++++++++++++
 tb/tb_csa_mul_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_mul_pipe.sv
// csa_mul_pipe: pipelined WIDTH x WIDTH multiplier (signed or unsigned per op).
// Partial products, including a sign-correction row, are reduced by 3:2
// carry-save layers spread over ranks 1..STAGES-1. Rank STAGES holds the
// carry-propagate sum. A single global stall freezes every rank while a
// result waits at the output.
module csa_mul_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int P    = 2*WIDTH;   // product width
  localparam int R    = WIDTH + 2; // WIDTH rows + negated top row + its +1 row
  localparam int MAXL = 32;        // loop bound, well above any real layer count

  typedef logic [R-1:0][P-1:0] rows_t;
  typedef logic [1:0][P-1:0]   pair_t;

  // Live row count entering layer l (each 3:2 layer turns n rows into n - n/3).
  function automatic int rows_at(input int l);
    int n;
    n = R;
    for (int i = 0; i < MAXL; i++)
      if (i < l && n > 2) n = n - n/3;
    return n;
  endfunction

  // Number of 3:2 layers needed to get from R rows down to two.
  function automatic int num_layers();
    int n;
    int c;
    n = R;
    c = 0;
    for (int i = 0; i < MAXL; i++)
      if (n > 2) begin
        n = n - n/3;
        c = c + 1;
      end
    return c;
  endfunction

  localparam int L   = num_layers();
  localparam int LPS = (L + STAGES - 2) / (STAGES - 1); // layers per CSA rank

  // One 3:2 layer over the first n rows. Full adders take rows in groups of
  // three; leftover rows (and the all-zero tail) shift down behind the
  // sum/carry pairs so the live rows stay packed at the bottom.
  function automatic rows_t csa_layer(input rows_t x, input int n);
    rows_t        o;
    logic [P-1:0] m;
    int           k;
    o = '0;
    k = n/3;
    for (int g = 0; g < R/3; g++)
      if (g < k) begin
        o[2*g]   = x[3*g] ^ x[3*g+1] ^ x[3*g+2];
        m        = (x[3*g] & x[3*g+1]) | (x[3*g] & x[3*g+2]) | (x[3*g+1] & x[3*g+2]);
        o[2*g+1] = {m[P-2:0], 1'b0};
      end
    for (int i = 0; i < R; i++)
      if (i >= 3*k) o[i-k] = x[i];
    return o;
  endfunction

  // Apply layers l0..l1-1 (clipped to the real layer count).
  function automatic rows_t csa_span(input rows_t x, input int l0, input int l1);
    rows_t y;
    y = x;
    for (int l = 0; l < MAXL; l++)
      if (l >= l0 && l < l1 && l < L) y = csa_layer(y, rows_at(l));
    return y;
  endfunction

  // After the last layer only the sum/carry pair is live.
  function automatic pair_t low2(input rows_t x);
    return x[1:0];
  endfunction

  logic [STAGES:1]  r_vld_pipe;
  logic [TAG_W-1:0] r_tag [1:STAGES-1];
  pair_t            r_pair;
  logic [P-1:0]     r_prod;
  logic [TAG_W-1:0] r_otag;

  logic             w_stall;
  logic             w_en;
  logic [P-1:0]     w_ax;
  logic             w_bs;
  rows_t            w_pp;
  rows_t            w_src [1:STAGES-1];

  assign w_stall   = r_vld_pipe[STAGES] & ~out_ready;
  assign w_en      = ~w_stall;
  assign in_ready  = ~w_stall;
  assign out_valid = r_vld_pipe[STAGES];
  assign out_prod  = r_prod;
  assign out_tag   = r_otag;
  assign busy      = |r_vld_pipe;

  // Partial products: a extended to the product width, one row per low b
  // bit; the b sign bit (weight -2^WIDTH) becomes ~a<<WIDTH plus 1<<WIDTH.
  always_comb begin
    w_ax = {{(P-WIDTH){in_signed & in_a[WIDTH-1]}}, in_a};
    w_bs = in_signed & in_b[WIDTH-1];
    w_pp = '0;
    for (int j = 0; j < WIDTH; j++)
      w_pp[j] = in_b[j] ? (w_ax << j) : '0;
    w_pp[WIDTH]   = w_bs ? (~w_ax << WIDTH) : '0;
    w_pp[WIDTH+1] = w_bs ? (P'(1) << WIDTH) : '0;
  end

  assign w_src[1] = w_pp;

  for (genvar s = 1; s < STAGES; s++) begin : g_rank
    rows_t w_red;
    assign w_red = csa_span(w_src[s], (s-1)*LPS, s*LPS);
    if (s < STAGES-1) begin : g_mid
      rows_t r_rows;
      // Intermediate carry-save rank; data only, validity lives in r_vld_pipe.
      always_ff @(posedge clk)
        if (w_en) r_rows <= w_red;
      assign w_src[s+1] = r_rows;
    end else begin : g_last
      // Last CSA rank keeps just the sum/carry pair for the final adder.
      always_ff @(posedge clk)
        if (w_en) r_pair <= low2(w_red);
    end
  end

  // Valid shift register; cleared asynchronously so in-flight ops vanish.
  always_ff @(posedge clk or posedge rst)
    if (rst)       r_vld_pipe <= '0;
    else if (w_en) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};

  // Tag travels alongside the data through the CSA ranks.
  always_ff @(posedge clk)
    if (w_en) begin
      r_tag[1] <= in_tag;
      for (int s = 2; s < STAGES; s++) r_tag[s] <= r_tag[s-1];
    end

  // Output rank: carry-propagate add; holds steady while stalled.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_prod <= '0;
      r_otag <= '0;
    end else if (w_en) begin
      r_prod <= r_pair[0] + r_pair[1];
      r_otag <= r_tag[STAGES-1];
    end

endmodule

// File: tb/tb_csa_mul_pipe.sv
// Bench for csa_mul_pipe: directed vector table, backpressure and reset
// sequences on a 32x32/4-stage unit, plus random streams on 8x8/2 and
// 16x16/6 instances checked against an arithmetic reference model.
module tb_csa_mul_pipe;

  localparam int S    = 4;
  localparam int NOPS = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        vi, ir, sg, ov, ordy, bz;
  logic [31:0] a_i, b_i;
  logic [4:0]  t, ot;
  logic [63:0] prod;
  bit          sweep_go;

  int total = 0;
  int bad   = 0;

  csa_mul_pipe #(.WIDTH(32), .STAGES(S), .TAG_W(5)) u_dut (
    .clk(clk), .rst(rst), .in_valid(vi), .in_ready(ir), .in_a(a_i), .in_b(b_i),
    .in_signed(sg), .in_tag(t), .out_valid(ov), .out_ready(ordy),
    .out_prod(prod), .out_tag(ot), .busy(bz)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Exact product of w-bit operands, reduced to 2w bits.
  function automatic longint unsigned refmul(input longint unsigned a, input longint unsigned b,
                                             input bit sgn, input int w);
    longint unsigned m, pm, ea, eb;
    m  = (64'd1 << w) - 64'd1;
    pm = (2*w >= 64) ? '1 : ((64'd1 << (2*w)) - 64'd1);
    ea = a & m;
    eb = b & m;
    if (sgn && ea[w-1]) ea = ea | ~m;
    if (sgn && eb[w-1]) eb = eb | ~m;
    return (ea * eb) & pm;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [4:0]  tag;
    logic [63:0] exp;
  } vec_t;
  vec_t vt [10];

  // Offer one op for a single cycle and check it lands exactly S cycles later.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [4:0] tg, input logic [63:0] exp, input string nm);
    @(negedge clk);
    a_i = a; b_i = b; sg = s; t = tg; vi = 1'b1;
    @(negedge clk);
    vi = 1'b0;
    repeat (S-2) @(negedge clk);
    chk({nm, "_early_valid"}, 64'(ov), 64'd0);
    chk({nm, "_busy"}, 64'(bz), 64'd1);
    @(negedge clk);
    chk({nm, "_valid"}, 64'(ov), 64'd1);
    chk({nm, "_prod"}, prod, exp);
    chk({nm, "_tag"}, 64'(ot), 64'(tg));
  endtask

  logic [63:0] mq [$];
  logic [4:0]  mt [$];
  logic [31:0] opa [8];
  logic [31:0] opb [8];
  bit          ops [8];

  initial begin
    int idx, got, sl;
    bit acc, snapped;
    logic [63:0] snap_p;
    logic [4:0]  snap_t;

    rst = 1'b1; vi = 1'b0; a_i = '0; b_i = '0; sg = 1'b0; t = '0; ordy = 1'b1; sweep_go = 1'b0;

    vt[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd3,  64'hFFFFFFFE00000001};
    vt[1] = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 5'd4,  64'hFFFFFFFFFFFFFFFE};
    vt[2] = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 5'd5,  64'h00000001FFFFFFFE};
    vt[3] = '{32'h80000000, 32'h80000000, 1'b1, 5'd6,  64'h4000000000000000};
    vt[4] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 5'd7,  64'hC000000080000000};
    vt[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd8,  64'h0000000000000001};
    vt[6] = '{32'h00000000, 32'h12345678, 1'b1, 5'd9,  64'h0000000000000000};
    vt[7] = '{32'h80000000, 32'h80000000, 1'b0, 5'd10, 64'h4000000000000000};
    vt[8] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 5'd11, 64'h3FFFFFFF00000001};
    vt[9] = '{32'h00000003, 32'hFFFFFFFD, 1'b1, 5'd31, 64'hFFFFFFFFFFFFFFF7};

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_busy", 64'(bz), 64'd0);
    chk("rst_prod", prod, 64'd0);
    chk("rst_tag", 64'(ot), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(ir), 64'd1);

    // Directed vectors
    for (int i = 0; i < 10; i++)
      run_op(vt[i].a, vt[i].b, vt[i].sg, vt[i].tag, vt[i].exp, $sformatf("vec%0d", i));

    // Streaming with a 3-cycle backpressure window after the first result
    for (int i = 0; i < 8; i++) begin
      opa[i] = $urandom; opb[i] = $urandom; ops[i] = 1'($urandom);
    end
    idx = 0; got = 0; sl = 0; acc = 1'b0; snapped = 1'b0; snap_p = '0; snap_t = '0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      @(negedge clk);
      if (acc) idx++;
      ordy = (sl == 0);
      if (sl > 0) sl--;
      #1;
      if (ov) begin
        if (ordy) begin
          if (mq.size() == 0) chk("bp_spurious", 64'(ot), 64'h1F);
          else begin
            chk("bp_prod", prod, mq.pop_front());
            chk("bp_tag", 64'(ot), 64'(mt.pop_front()));
            if (snapped) begin
              chk("bp_hold_prod", prod, snap_p);
              chk("bp_hold_tag", 64'(ot), 64'(snap_t));
            end
            snapped = 1'b0;
            got++;
            if (got == 1) sl = 3;
          end
        end else begin
          chk("bp_in_ready", 64'(ir), 64'd0);
          if (!snapped) begin
            snap_p = prod; snap_t = ot; snapped = 1'b1;
          end else begin
            chk("bp_stable_prod", prod, snap_p);
            chk("bp_stable_tag", 64'(ot), 64'(snap_t));
          end
        end
      end
      vi = (idx < 8);
      if (idx < 8) begin
        a_i = opa[idx]; b_i = opb[idx]; sg = ops[idx]; t = 5'(idx);
      end
      acc = vi && !(ov && !ordy);
      if (acc) begin
        mq.push_back(refmul(64'(opa[idx]), 64'(opb[idx]), ops[idx], 32));
        mt.push_back(5'(idx));
      end
    end
    vi = 1'b0; ordy = 1'b1;
    chk("bp_count", 64'(got), 64'd8);
    chk("bp_leftover", 64'(mq.size()), 64'd0);

    // Reset while three ops are in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vi = 1'b1; a_i = 32'(i + 1); b_i = 32'd7; sg = 1'b0; t = 5'(i);
    end
    @(negedge clk);
    vi = 1'b0;
    @(negedge clk);
    chk("rmf_valid_before", 64'(ov), 64'd1);
    chk("rmf_busy_before", 64'(bz), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmf_valid_drop", 64'(ov), 64'd0);
    chk("rmf_busy_drop", 64'(bz), 64'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < S + 2; i++) begin
      @(negedge clk);
      chk("rmf_quiet_valid", 64'(ov), 64'd0);
      chk("rmf_quiet_busy", 64'(bz), 64'd0);
    end
    run_op(32'd3, 32'd5, 1'b0, 5'd21, 64'd15, "rmf_fresh");

    // Random streams on the other geometries
    sweep_go = 1'b1;
    for (int i = 0; i < 20000 && !(g_sw[0].done && g_sw[1].done); i++) @(negedge clk);
    chk("sweep_done", 64'({g_sw[1].done, g_sw[0].done}), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  for (genvar k = 0; k < 2; k++) begin : g_sw
    localparam int W  = (k == 0) ? 8 : 16;
    localparam int SS = (k == 0) ? 2 : 6;
    logic           vi_s, ir_s, sg_s, ov_s, bz_s;
    logic [W-1:0]   a_s, b_s;
    logic [4:0]     t_s, ot_s;
    logic [2*W-1:0] p_s;
    bit             done = 1'b0;

    csa_mul_pipe #(.WIDTH(W), .STAGES(SS), .TAG_W(5)) u_sw (
      .clk(clk), .rst(rst), .in_valid(vi_s), .in_ready(ir_s), .in_a(a_s), .in_b(b_s),
      .in_signed(sg_s), .in_tag(t_s), .out_valid(ov_s), .out_ready(1'b1),
      .out_prod(p_s), .out_tag(ot_s), .busy(bz_s)
    );

    initial begin
      longint unsigned qe [$];
      int              qc [$];
      logic [4:0]      qt [$];
      vi_s = 1'b0; a_s = '0; b_s = '0; sg_s = 1'b0; t_s = '0;
      wait (sweep_go);
      for (int c = 0; c < NOPS + SS + 2; c++) begin
        @(negedge clk);
        chk($sformatf("sw%0d_in_ready", W), 64'(ir_s), 64'd1);
        chk($sformatf("sw%0d_busy", W), 64'(bz_s), 64'(qe.size() > 0));
        if (ov_s) begin
          if (qe.size() == 0) chk($sformatf("sw%0d_spurious", W), 64'(ov_s), 64'd0);
          else begin
            chk($sformatf("sw%0d_prod", W), 64'(p_s), qe.pop_front());
            chk($sformatf("sw%0d_tag", W), 64'(ot_s), 64'(qt.pop_front()));
            chk($sformatf("sw%0d_latency", W), 64'(c), 64'(qc.pop_front() + SS));
          end
        end else if (qe.size() > 0 && qc[0] + SS == c)
          chk($sformatf("sw%0d_missing", W), 64'(ov_s), 64'd1);
        vi_s = (c < NOPS) && ($urandom_range(0, 3) != 0);
        a_s  = W'($urandom);
        b_s  = W'($urandom);
        sg_s = 1'($urandom);
        t_s  = 5'($urandom);
        if (vi_s) begin
          qe.push_back(refmul(64'(a_s), 64'(b_s), sg_s, W));
          qc.push_back(c);
          qt.push_back(t_s);
        end
      end
      chk($sformatf("sw%0d_leftover", W), 64'(qe.size()), 64'd0);
      done = 1'b1;
    end
  end

endmodule
